lsu_mem_bridge: RTL and testbench

//  Load/store responder for the decoded memory-control outputs of the single-cycle core.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_align.sv | 62 ++++++
 rtl/lsu_mem_bridge.sv | 155 +++++++++++++++
 tb/tb_lsu_mem_bridge.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store bridge: RV32I funct3 codes and FSM state encoding.
package lsu_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_RESP = 2'd2,
        DONE     = 2'd3
    } state_t;
endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: byte enables and store replication, access checks,
// and load-data extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic        we,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign,
    output logic        illegal,
    output logic [31:0] rdata
);
    logic [31:0] shifted;

    always_comb begin
        be       = 4'b0000;
        wdata    = 32'd0;
        misalign = 1'b0;
        illegal  = 1'b0;
        rdata    = 32'd0;
        shifted  = rdata_in >> {off, 3'b000};

        // Size is funct3[1:0]; funct3[2] only selects unsigned loads.
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                misalign = off[0];
                be       = 4'b0011 << {off[1], 1'b0};
                wdata    = {2{wdata_in[15:0]}};
            end
            2'b10: begin
                misalign = (off != 2'b00);
                be       = 4'b1111;
                wdata    = wdata_in;
            end
            default: illegal = 1'b1;
        endcase

        if (we)
            illegal = illegal | funct3[2];
        else begin
            illegal = illegal | (funct3[2:1] == 2'b11);
            be      = 4'b1111;
        end

        case (funct3)
            F3_LB:   rdata = {{24{shifted[7]}}, shifted[7:0]};
            F3_LH:   rdata = {{16{shifted[15]}}, shifted[15:0]};
            F3_LW:   rdata = shifted;
            F3_LBU:  rdata = {24'd0, shifted[7:0]};
            F3_LHU:  rdata = {16'd0, shifted[15:0]};
            default: rdata = 32'd0;
        endcase
    end
endmodule

// File: rtl/lsu_mem_bridge.sv
// Stalls the core for one load/store, runs a valid/ready word-bus transaction,
// and returns extended load data or an error pulse.
module lsu_mem_bridge
    import lsu_pkg::*;
#(
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] RESET_RDATA = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        err,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state, state_nx;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic        we_q;

    logic        accept, bad, timeout;
    logic        rsp_set, err_set, data_set;
    logic [2:0]  f3_sel;
    logic [1:0]  off_sel;
    logic        we_sel;
    logic [3:0]  be_c;
    logic [31:0] wdata_c, rdata_c;
    logic        misalign_c, illegal_c;

    // Decode live request fields while idle, captured fields once the bus is busy.
    assign f3_sel  = (state == IDLE) ? req_funct3    : f3_q;
    assign off_sel = (state == IDLE) ? req_addr[1:0] : off_q;
    assign we_sel  = (state == IDLE) ? req_we        : we_q;

    lsu_align u_align (
        .funct3   (f3_sel),
        .off      (off_sel),
        .we       (we_sel),
        .wdata_in (req_wdata),
        .rdata_in (bus_rdata),
        .be       (be_c),
        .wdata    (wdata_c),
        .misalign (misalign_c),
        .illegal  (illegal_c),
        .rdata    (rdata_c)
    );

    assign stall   = req_valid & ~rsp_valid;
    assign accept  = (state == IDLE) & req_valid & ~rsp_valid;
    assign bad     = misalign_c | illegal_c;
    assign timeout = (cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rsp_set  = 1'b0;
        err_set  = 1'b0;
        data_set = 1'b0;
        case (state)
            IDLE: if (accept) begin
                state_nx = bad ? DONE : BUS_REQ;
                rsp_set  = bad;
                err_set  = bad;
            end
            BUS_REQ: begin
                // Completion wins over a timeout landing on the same cycle.
                if (bus_ready && (we_q || bus_rvalid)) begin
                    state_nx = DONE;
                    rsp_set  = 1'b1;
                    data_set = ~we_q;
                end else if (bus_ready) begin
                    state_nx = BUS_RESP;
                end else if (timeout) begin
                    state_nx = DONE;
                    rsp_set  = 1'b1;
                    err_set  = 1'b1;
                end
            end
            BUS_RESP: begin
                if (bus_rvalid) begin
                    state_nx = DONE;
                    rsp_set  = 1'b1;
                    data_set = 1'b1;
                end else if (timeout) begin
                    state_nx = DONE;
                    rsp_set  = 1'b1;
                    err_set  = 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0000;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            rsp_rdata <= RESET_RDATA;
            cnt       <= 8'd0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            we_q      <= 1'b0;
        end else begin
            rsp_valid <= rsp_set;
            err       <= err_set;
            if (rsp_set)
                rsp_rdata <= err_set ? RESET_RDATA : (data_set ? rdata_c : 32'd0);

            if (accept) begin
                f3_q  <= req_funct3;
                off_q <= req_addr[1:0];
                we_q  <= req_we;
                cnt   <= 8'd0;
                if (!bad) begin
                    bus_valid <= 1'b1;
                    bus_we    <= req_we;
                    bus_be    <= be_c;
                    bus_addr  <= {req_addr[31:2], 2'b00};
                    bus_wdata <= wdata_c;
                end
            end else if (state == BUS_REQ || state == BUS_RESP) begin
                cnt <= cnt + 8'd1;
            end

            if (state == BUS_REQ && state_nx != BUS_REQ)
                bus_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge: stores, loads, error cases, timeout and async reset.
module tb_lsu_mem_bridge;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, rsp_valid, err;
    logic [31:0] rsp_rdata;
    logic        bus_valid, bus_ready, bus_we, bus_rvalid;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int total  = 0;
    int passed = 0;

    lsu_mem_bridge dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
    endtask

    task automatic finish_rsp();
        req_valid = 1'b0; bus_ready = 1'b0; bus_rvalid = 1'b0;
        step();
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] exp_be, input logic [31:0] exp_wd);
        issue(1'b1, f3, a, d);
        step();
        chk({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
        chk({tag, "_be"}, {28'd0, bus_be}, {28'd0, exp_be});
        chk({tag, "_wdata"}, bus_wdata, exp_wd);
        bus_ready = 1'b1;
        step();
        chk({tag, "_rsp"}, {30'd0, rsp_valid, err}, 32'd2);
        finish_rsp();
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] raw, input logic [31:0] exp);
        issue(1'b0, f3, a, 32'd0);
        step();
        chk({tag, "_req"}, {27'd0, bus_valid, bus_we, bus_be}, {27'd0, 2'b10, 4'b1111});
        bus_ready = 1'b1;
        step();
        chk({tag, "_vdrop"}, {31'd0, bus_valid}, 32'd0);
        bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = raw;
        step();
        chk({tag, "_rsp"}, {30'd0, rsp_valid, err}, 32'd2);
        chk({tag, "_data"}, rsp_rdata, exp);
        finish_rsp();
    endtask

    task automatic do_bad(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a);
        issue(we, f3, a, 32'h1234_5678);
        step();
        chk({tag, "_rsp"}, {29'd0, rsp_valid, err, bus_valid}, 32'd6);
        chk({tag, "_data"}, rsp_rdata, 32'd0);
        finish_rsp();
    endtask

    initial begin
        int n;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        step(); step();
        chk("reset_outs", {27'd0, bus_valid, rsp_valid, err, bus_we, stall}, 32'd0);
        chk("reset_be", {28'd0, bus_be}, 32'd0);
        chk("reset_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        step();

        // SW with one wait cycle before bus_ready
        issue(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
        #1 chk("sw_stall", {31'd0, stall}, 32'd1);
        step();
        chk("sw_be", {27'd0, bus_valid, bus_be}, {27'd0, 1'b1, 4'b1111});
        chk("sw_wdata", bus_wdata, 32'hDEAD_BEEF);
        step();
        chk("sw_hold", {31'd0, bus_valid}, 32'd1);
        bus_ready = 1'b1;
        step();
        chk("sw_rsp", {29'd0, rsp_valid, err, stall}, 32'd4);
        chk("sw_rdata", rsp_rdata, 32'd0);
        finish_rsp();

        do_store("sb", 3'b000, 32'h103, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
        do_store("sh", 3'b001, 32'h102, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);

        do_load("lb",  3'b000, 32'h101, 32'h1234_80FF, 32'hFFFF_FF80);
        do_load("lbu", 3'b100, 32'h101, 32'h1234_80FF, 32'h0000_0080);
        do_load("lhu", 3'b101, 32'h102, 32'h1234_80FF, 32'h0000_1234);
        do_load("lh",  3'b001, 32'h100, 32'h1234_80FF, 32'hFFFF_80FF);
        do_load("lw",  3'b010, 32'h100, 32'h1234_80FF, 32'h1234_80FF);

        // bus_ready and bus_rvalid together in BUS_REQ: load completes in two cycles
        issue(1'b0, 3'b100, 32'h103, 32'd0);
        step();
        bus_ready = 1'b1; bus_rvalid = 1'b1; bus_rdata = 32'hC3_00_00_00;
        step();
        chk("fast_rsp", {30'd0, rsp_valid, err}, 32'd2);
        chk("fast_data", rsp_rdata, 32'h0000_00C3);
        finish_rsp();

        do_bad("lw_mis", 1'b0, 3'b010, 32'h102);
        do_bad("lh_mis", 1'b0, 3'b001, 32'h101);
        do_bad("ld_f3",  1'b0, 3'b011, 32'h100);
        do_bad("st_f3",  1'b1, 3'b100, 32'h100);

        // Timeout in BUS_RESP: 255 bus cycles, then DONE
        issue(1'b0, 3'b010, 32'h200, 32'd0);
        step(); n = 1;
        bus_ready = 1'b1;
        step(); n++;
        bus_ready = 1'b0;
        while (!rsp_valid && n < 400) begin
            step(); n++;
        end
        chk("to_latency", n, 256);
        chk("to_rsp", {30'd0, rsp_valid, err}, 32'd3);
        chk("to_rdata", rsp_rdata, 32'd0);
        req_valid = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        step(); step();
        chk("to_late", {30'd0, rsp_valid, bus_valid}, 32'd0);
        bus_rvalid = 1'b0;
        step();

        // Reset during BUS_REQ drops bus_valid without a clock edge
        issue(1'b0, 3'b010, 32'h300, 32'd0);
        step();
        chk("rq_valid", {31'd0, bus_valid}, 32'd1);
        reset = 1'b1;
        #1 chk("rq_async", {31'd0, bus_valid}, 32'd0);
        step(); reset = 1'b0; req_valid = 1'b0;
        step();

        // Reset during BUS_RESP, late rvalid ignored, then a normal LW
        issue(1'b0, 3'b010, 32'h300, 32'd0);
        step(); bus_ready = 1'b1;
        step(); bus_ready = 1'b0;
        reset = 1'b1;
        #1 chk("rr_async", {30'd0, bus_valid, rsp_valid}, 32'd0);
        step(); reset = 1'b0; req_valid = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h5555_5555;
        step(); step();
        chk("rr_ignore", {30'd0, rsp_valid, bus_valid}, 32'd0);
        bus_rvalid = 1'b0;
        step();
        do_load("post_rst", 3'b010, 32'h304, 32'hCAFE_F00D, 32'hCAFE_F00D);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
